sram_like_slave: RTL

Responder side of the sram-like bus our core's instruction and data ports drive, i.e. the memory end of `req`/`addr_ok`/`data_ok`. It accepts pipelined sram-like requests, queues them, and issues them one per cycle to a synchronous single-port SRAM with 1-cycle read latency. Each accepted request gets exactly one `data_ok` pulse, in acceptance order. It serves as the on-chip memory behind either core port, and as the bench memory model when the core is tested without the AXI bridge.

---
 rtl/sram_like_slave.sv | 77 +++++++
 1 files changed

// File: rtl/sram_like_slave.sv
// sram_like_slave: sram-like bus responder that queues requests onto a 1-cycle-latency single-port SRAM.
// Define SRAM_LIKE_SLAVE_STALL_EN to add LFSR-driven addr_ok backpressure.
module sram_like_slave #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        ram_en,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);
  localparam logic [2:0] W_DEPTH = 3'(DEPTH);
  localparam logic [1:0] W_LAST = 2'(DEPTH - 1);
  typedef struct packed {
    logic        wr;
    logic [3:0]  mask;
    logic [29:0] waddr;
    logic [31:0] wdata;
  } entry_t;
  entry_t      r_q [4];
  entry_t      w_head;
  logic [1:0]  r_wptr, r_rptr;
  logic [2:0]  r_qcnt, r_cnt;
  logic        r_rsp_v, r_rsp_wr;
  logic        w_push, w_pop, w_room;
  logic [3:0]  w_mask;
  assign w_mask = size == 2'd0 ? 4'b0001 << addr[1:0] :
                  size == 2'd1 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  // Subtracting the response leaving this cycle lets a full slave accept in the same cycle.
  assign w_room = (r_cnt - {2'b00, r_rsp_v}) < W_DEPTH;
`ifdef SRAM_LIKE_SLAVE_STALL_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge clk)
    r_lfsr <= rst ? 16'hACE1 : {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign addr_ok = w_room & (rst | (|r_lfsr[1:0]));
`else
  assign addr_ok = w_room;
`endif
  assign w_push = req & addr_ok & ~rst;
  assign w_pop = (r_qcnt != 3'd0) & ~rst;
  assign w_head = r_q[r_rptr];
  assign ram_en = w_pop;
  assign ram_wen = (w_pop & w_head.wr) ? w_head.mask : 4'b0000;
  assign ram_addr = {w_head.waddr, 2'b00};
  assign ram_wdata = w_head.wdata;
  assign data_ok = r_rsp_v;
  assign rdata = (r_rsp_v & ~r_rsp_wr) ? ram_rdata : 32'h0;
  always_ff @(posedge clk)
    if (w_push) r_q[r_wptr] <= '{wr: wr, mask: w_mask, waddr: addr[31:2], wdata: wdata};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr   <= 2'd0;
      r_rptr   <= 2'd0;
      r_qcnt   <= 3'd0;
      r_cnt    <= 3'd0;
      r_rsp_v  <= 1'b0;
      r_rsp_wr <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr == W_LAST ? 2'd0 : r_wptr + 2'd1;
      if (w_pop) r_rptr <= r_rptr == W_LAST ? 2'd0 : r_rptr + 2'd1;
      r_qcnt   <= r_qcnt + {2'b00, w_push} - {2'b00, w_pop};
      r_cnt    <= r_cnt + {2'b00, w_push} - {2'b00, r_rsp_v};
      r_rsp_v  <= w_pop;
      r_rsp_wr <= w_head.wr;
    end
  end
endmodule
